// File: rtl/ut_pkg.sv
// Shared definitions for the UT processing unit: operation encodings and
// the multiply sequencer state type.
package ut_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_LOAD = 3'b000;
    localparam op_t OP_AND  = 3'b001;
    localparam op_t OP_OR   = 3'b010;
    localparam op_t OP_XOR  = 3'b011;
    localparam op_t OP_ADD  = 3'b100;
    localparam op_t OP_SUB  = 3'b101;
    localparam op_t OP_ADC  = 3'b110;
    localparam op_t OP_MUL  = 3'b111;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_t;

endpackage

// File: rtl/ut_mc_if.sv
// Sequencer-facing strobe/status bundle of the UT processing unit.
interface ut_mc_if #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4
);
    localparam int AW = $clog2(NREG);

    logic             ce;
    logic [2:0]       sel_ual;
    logic             load_reg;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic             load_accu;
    logic             load_carry;
    logic             init_carry;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             carry;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output ce, sel_ual, load_reg, wr_addr, rd_addr,
               load_accu, load_carry, init_carry, data_in,
        input  data_out, carry, zero, busy, done
    );

    modport slave (
        input  ce, sel_ual, load_reg, wr_addr, rd_addr,
               load_accu, load_carry, init_carry, data_in,
        output data_out, carry, zero, busy, done
    );
endinterface

// File: rtl/ut_alu.sv
// Single-cycle combinational ALU of the UT; LOAD and MUL results are
// produced elsewhere, so both return zero here.
module ut_alu
    import ut_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  op_t              op,
    output logic [WIDTH-1:0] result,
    output logic             cout
);
    logic [WIDTH:0] wide;

    // The extra top bit carries out for ADD/ADC and the borrow for SUB.
    always_comb begin
        wide = '0;
        case (op)
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_ADC:  wide = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
            default: wide = '0;
        endcase
        result = wide[WIDTH-1:0];
        cout   = wide[WIDTH];
    end
endmodule

// File: rtl/ut_mc.sv
// UT processing unit: accumulator, operand register file, flags and a
// WIDTH-step shift-add multiplier, all outputs driven straight from flops.
module ut_mc
    import ut_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREG  = 4
) (
    input logic clk,
    input logic rst,
    ut_mc_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   accu_q;
    logic [WIDTH-1:0]   regs_q [NREG];
    logic               carry_q, zero_q, busy_q, done_q;
    mul_state_t         state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;

    logic [WIDTH-1:0]   opb, alu_res, res_d;
    logic               alu_cout, en, mul_start;
    logic [WIDTH:0]     psum;
    logic [2*WIDTH-1:0] prod_d;

    assign en        = bus.ce && !busy_q;
    assign mul_start = bus.load_accu && (op_t'(bus.sel_ual) == OP_MUL);
    assign opb       = regs_q[bus.rd_addr];

    ut_alu #(.WIDTH(WIDTH)) u_alu (
        .a        (accu_q),
        .b        (opb),
        .carry_in (carry_q),
        .op       (op_t'(bus.sel_ual)),
        .result   (alu_res),
        .cout     (alu_cout)
    );

    assign res_d = (op_t'(bus.sel_ual) == OP_LOAD) ? bus.data_in : alu_res;

    // Multiplier lives in the low half; partial sum accumulates in the high half.
    always_comb begin
        psum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_d = {psum, prod_q[WIDTH-1:1]};
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                regs_q[gi] <= '0;
            end else if (en && bus.load_reg && bus.wr_addr == AW'(gi)) begin
                regs_q[gi] <= bus.data_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accu_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else if (bus.ce) begin
            done_q <= 1'b0;
            if (state_q == MUL_RUN) begin
                prod_q <= prod_d;
                cnt_q  <= cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    accu_q  <= prod_d[WIDTH-1:0];
                    carry_q <= |prod_d[2*WIDTH-1:WIDTH];
                    zero_q  <= (prod_d[WIDTH-1:0] == '0);
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= MUL_IDLE;
                    cnt_q   <= '0;
                end
            end else if (mul_start) begin
                mcand_q <= accu_q;
                prod_q  <= {{WIDTH{1'b0}}, opb};
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= MUL_RUN;
            end else begin
                if (bus.load_accu) begin
                    accu_q <= res_d;
                    zero_q <= (res_d == '0);
                end
                if (bus.init_carry) begin
                    carry_q <= 1'b0;
                end else if (bus.load_carry) begin
                    carry_q <= alu_cout;
                end
            end
        end
    end

    assign bus.data_out = accu_q;
    assign bus.carry    = carry_q;
    assign bus.zero     = zero_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_ut_mc.sv
// Scoreboarded bench for ut_mc: directed scenarios then random operations,
// checked against an arithmetic reference model of the unit.
module tb_ut_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;

    ut_mc_if #(.WIDTH(8), .NREG(4)) bus ();
    ut_mc #(.WIDTH(8), .NREG(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int    accu;
        int    carry;
        int    zero;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   obs_cnt = 0;
    int   obs_seen = 0;

    int m_accu, m_carry, m_zero;
    int m_r[4];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_accu = 0; m_carry = 0; m_zero = 0;
        for (int i = 0; i < 4; i++) m_r[i] = 0;
    endtask

    task automatic idle();
        bus.load_reg = 0; bus.load_accu = 0; bus.load_carry = 0; bus.init_carry = 0;
        bus.sel_ual = 3'd0; bus.wr_addr = 2'd0; bus.rd_addr = 2'd0; bus.data_in = 8'd0;
    endtask

    // Issued at posedge+1; applies one operation and queues the expected state.
    task automatic op(input string tag, input int s, input bit la, input bit lc, input bit ic,
                      input bit lr, input int wa, input int ra, input int d);
        int a, b, res, cout, sum, p;
        exp_t e;
        bus.sel_ual = 3'(s); bus.load_accu = la; bus.load_carry = lc; bus.init_carry = ic;
        bus.load_reg = lr; bus.wr_addr = 2'(wa); bus.rd_addr = 2'(ra); bus.data_in = 8'(d);
        a = m_accu; b = m_r[ra]; cout = 0; res = 0;
        case (s)
            0: res = d;
            1: res = a & b;
            2: res = a | b;
            3: res = a ^ b;
            4: begin sum = a + b; res = sum % 256; cout = (sum > 255); end
            5: begin res = (a - b + 256) % 256; cout = (a < b); end
            6: begin sum = a + b + m_carry; res = sum % 256; cout = (sum > 255); end
            default: res = 0;
        endcase
        if (lr) m_r[wa] = d;
        if (la && s == 7) begin
            p = a * b;
            m_accu = p % 256; m_carry = (p > 255); m_zero = (m_accu == 0);
        end else begin
            if (la) begin m_accu = res; m_zero = (res == 0); end
            if (ic) m_carry = 0;
            else if (lc) m_carry = cout;
        end
        e.accu = m_accu; e.carry = m_carry; e.zero = m_zero; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk); #1;
        idle();
        if (!(la && s == 7)) obs_cnt++;
    endtask

    // Called at posedge+1 right after a MUL start edge.
    task automatic wait_mul(input string tag, input int gs, input int gl, input bit junk,
                            output int tot);
        int en_busy, cyc;
        bit finished;
        en_busy = 0; cyc = 0; tot = 0; finished = 0;
        while (cyc < 100) begin
            if (junk) begin
                bus.load_reg = 1; bus.load_accu = 1; bus.load_carry = 1;
                bus.init_carry = 1'($urandom_range(0, 1));
                bus.sel_ual = 3'($urandom_range(0, 7)); bus.wr_addr = 2'($urandom_range(0, 3));
                bus.rd_addr = 2'($urandom_range(0, 3)); bus.data_in = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            if (!bus.busy) begin finished = 1; break; end
            tot++;
            if (bus.ce) en_busy++;
            @(posedge clk); #1;
            cyc++;
            bus.ce = (cyc >= gs && cyc < gs + gl) ? 1'b0 : 1'b1;
        end
        idle();
        bus.ce = 1;
        if (!finished) begin
            chk({tag, ".timeout"}, 1, 0);
        end else begin
            chk({tag, ".enabled_busy_cycles"}, en_busy, 8);
            chk({tag, ".done_at_end"}, int'(bus.done), 1);
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, ".done_single_pulse"}, int'(bus.done), 0);
        end
        @(posedge clk); #1;
    endtask

    // Monitor: pops an expectation when the DUT completes a multiply or an
    // observation slot for a single-cycle operation is pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (bus.done || obs_cnt != obs_seen)) begin
                if (!bus.done) obs_seen++;
                if (exp_q.size() == 0) begin
                    chk("scoreboard_unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.tag, ".accu"},  int'(bus.data_out), e.accu);
                    chk({e.tag, ".carry"}, int'(bus.carry),    e.carry);
                    chk({e.tag, ".zero"},  int'(bus.zero),     e.zero);
                    $display("txn %s: accu=0x%02h carry=%0d zero=%0d", e.tag, bus.data_out, bus.carry, bus.zero);
                end
            end
        end
    end

    initial begin
        int tot, dn, s, la, ra;
        model_reset();
        bus.ce = 1;
        bus.sel_ual = 3'($urandom_range(0, 7)); bus.load_reg = 1; bus.load_accu = 1;
        bus.load_carry = 1; bus.init_carry = 0; bus.wr_addr = 2'd1; bus.rd_addr = 2'd1;
        bus.data_in = 8'($urandom_range(1, 255));
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        idle();
        @(negedge clk);
        chk("reset.data_out", int'(bus.data_out), 0);
        chk("reset.carry",    int'(bus.carry), 0);
        chk("reset.zero",     int'(bus.zero), 0);
        chk("reset.busy",     int'(bus.busy), 0);
        chk("reset.done",     int'(bus.done), 0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) op($sformatf("reset_read_r%0d", i), 4, 1, 0, 0, 0, 0, i, 0);

        // ADD / ADC
        op("load_f0", 0, 1, 0, 0, 0, 0, 0, 'hF0);
        op("r1_20",   0, 0, 0, 0, 1, 1, 0, 'h20);
        op("add_r1",  4, 1, 1, 0, 0, 0, 1, 0);
        op("r2_00",   0, 0, 0, 0, 1, 2, 0, 'h00);
        op("adc_r2",  6, 1, 1, 0, 0, 0, 2, 0);

        // SUB / zero
        op("load_05", 0, 1, 0, 0, 0, 0, 0, 'h05);
        op("r0_07",   0, 0, 0, 0, 1, 0, 0, 'h07);
        op("sub_borrow", 5, 1, 1, 0, 0, 0, 0, 0);
        op("load_07", 0, 1, 0, 0, 0, 0, 0, 'h07);
        op("sub_zero",   5, 1, 1, 0, 0, 0, 0, 0);

        // MUL
        op("load_0c", 0, 1, 0, 0, 0, 0, 0, 'h0C);
        op("r3_0b",   0, 0, 0, 0, 1, 3, 0, 'h0B);
        op("mul_0c_0b", 7, 1, 0, 0, 0, 0, 3, 0);
        wait_mul("mul_0c_0b", 100, 0, 0, tot);
        op("load_20", 0, 1, 0, 0, 0, 0, 0, 'h20);
        op("r3_10",   0, 0, 0, 0, 1, 3, 0, 'h10);
        op("mul_ovf", 7, 1, 0, 0, 0, 0, 3, 0);
        wait_mul("mul_ovf", 100, 0, 0, tot);
        op("load_0c_b", 0, 1, 0, 0, 0, 0, 0, 'h0C);
        op("r3_0b_b",   0, 0, 0, 0, 1, 3, 0, 'h0B);
        op("mul_ce_gap", 7, 1, 0, 0, 0, 0, 3, 0);
        wait_mul("mul_ce_gap", 3, 3, 0, tot);
        chk("mul_ce_gap.busy_cycles", tot, 11);

        // Lockout: strobes during a multiply must not touch R or accu
        op("load_03", 0, 1, 0, 0, 0, 0, 0, 'h03);
        op("mul_lockout", 7, 1, 0, 0, 0, 0, 3, 0);
        wait_mul("mul_lockout", 100, 0, 1, tot);
        for (int i = 0; i < 4; i++) op($sformatf("lockout_or_r%0d", i), 2, 1, 0, 0, 0, 0, i, 0);

        // Abort by reset mid-multiply
        op("mul_abort", 7, 1, 0, 0, 0, 0, 3, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        void'(exp_q.pop_back());
        model_reset();
        @(negedge clk);
        chk("abort.busy", int'(bus.busy), 0);
        chk("abort.data_out", int'(bus.data_out), 0);
        chk("abort.done", int'(bus.done), 0);
        @(posedge clk); #1;
        rst = 0;
        dn = 0;
        repeat (12) begin @(negedge clk); dn += int'(bus.done); end
        chk("abort.no_done_pulse", dn, 0);
        @(posedge clk); #1;
        op("abort_read_r3", 4, 1, 0, 0, 0, 0, 3, 0);

        // Priority and simultaneity
        op("load_f0_p", 0, 1, 0, 0, 0, 0, 0, 'hF0);
        op("r1_20_p",   0, 0, 0, 0, 1, 1, 0, 'h20);
        op("add_initcarry", 4, 1, 1, 1, 0, 0, 1, 0);
        op("load_05_p", 0, 1, 0, 0, 0, 0, 0, 'h05);
        op("r1_03",     0, 0, 0, 0, 1, 1, 0, 'h03);
        op("add_old_r1", 4, 1, 0, 0, 1, 1, 1, 'h01);
        op("add_new_r1", 4, 1, 0, 0, 0, 0, 1, 0);

        // Random operations
        for (int n = 0; n < 300; n++) begin
            s  = $urandom_range(0, 7);
            la = ($urandom_range(0, 3) != 0);
            ra = $urandom_range(0, 3);
            op($sformatf("rnd%0d_op%0d", n, s), s, 1'(la), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), ra, $urandom_range(0, 255));
            if (la && s == 7)
                wait_mul($sformatf("rnd%0d_mul", n), $urandom_range(1, 6), $urandom_range(0, 2),
                         1'($urandom_range(0, 1)), tot);
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
